uart_tx: RTL and testbench
==========================

# uart_tx

Serial transmitter for the memory-mapped UART TX port. Consumes the byte and active-low start strobe driven by the memory-map stage, emits one 8N1 frame (start bit, 8 data bits LSB-first, one stop bit) on the `tx` pin, and reports idle/busy back through `ready`. The memory-map stage exposes `ready` to software as the TX-ready register.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
- `start_n`  in  1  active-low transmit request; a falling edge requests a frame.
- `tx_byte`  in  8  byte to send; sampled on the accepting edge only.
- `ready`  out  1  1 = idle and able to accept; 0 = frame in progress.
- `tx`  out  1  serial line; idles high.

## Operation
- States: IDLE, START, DATA, STOP.
- Edge detect: register `start_n_q` (reset 1) updated every cycle. Request = `start_n == 0 && start_n_q == 1`.
- IDLE: `tx = 1`, `ready = 1`. On a request, latch `tx_byte` into the shift register, clear the bit counter and baud counter, go to START.
- START: `tx = 0` for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
- DATA: `tx = shift[0]` for `CLKS_PER_BIT` cycles, then shift right and increment the index. After index 7 completes, go to STOP.
- STOP: `tx = 1` for `CLKS_PER_BIT` cycles, then go to IDLE.
- `ready = (state == IDLE)`, registered with the state.
- Requests outside IDLE are ignored and not queued. This includes a request on the same edge that leaves STOP.
- A `start_n` held low does not retrigger. `start_n` must return high and fall again. The memory-map stage releases `start_n` on the rising edge of `ready`, which re-arms the transmitter.
- `tx_byte` changes after acceptance do not affect the frame in flight.
- Baud counter width is `$clog2(CLKS_PER_BIT)`. It counts 0..`CLKS_PER_BIT-1` and wraps to 0 at each bit boundary.

## Timing
- Reset values: `state = IDLE`, `tx = 1`, `ready = 1`, `start_n_q = 1`, counters 0, shift register 0.
- Reset mid-frame forces `tx = 1` and `ready = 1` immediately (asynchronously). The frame is abandoned.
- Accepting edge T (`start_n` sampled low, `start_n_q` high, state IDLE):
  - `tx` falls and `ready` falls at T.
- Data bit k drives `tx` from T + (1+k)·`CLKS_PER_BIT`.
- Stop bit drives `tx` from T + 9·`CLKS_PER_BIT`.
- `ready` returns to 1 at T + 10·`CLKS_PER_BIT`. Frame length is exactly 10·`CLKS_PER_BIT` cycles.
- Earliest next acceptance is one cycle after `start_n` has been seen high while in IDLE.
- `tx` and `ready` are registered outputs with no combinational path from the inputs.

## Structure
- Shared package `uart_pkg`:
  - `uart_tx_state_t` enum (IDLE, START, DATA, STOP).
  - `UART_DEFAULT_CLKS_PER_BIT = 434`.
  - `UART_DATA_BITS = 8`.
- Single module; no sub-module. The baud counter and bit counter are inline.

## Test plan
- Reset: assert `rst` mid-DATA with `CLKS_PER_BIT = 4` → `tx = 1` and `ready = 1` within the same cycle. After release, stays idle with no spurious frame.
- Basic frame: `CLKS_PER_BIT = 4`, `tx_byte = 8'h55`, pulse `start_n` low → `tx` = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles. `ready` low for exactly 40 cycles.
- LSB-first check: `tx_byte = 8'h01` → data bits 1,0,0,0,0,0,0,0. Then `tx_byte = 8'h80` → data bits 0,0,0,0,0,0,0,1.
- Held strobe: hold `start_n` low for 100 cycles with `CLKS_PER_BIT = 4` → exactly one frame; `ready` rises at cycle 40 and stays 1.
- Busy request: a second `start_n` falling edge at cycle 20 of a frame → ignored. `tx` shows only the first byte and `ready` rises at cycle 40.
- Handshake with the memory-map stage: software writes 0x41 then 0x42 to the TX-byte address, polling TX-ready between writes → two back-to-back correct frames. `start_n` is released after each `ready` rise.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
//
// Contents:
//   uart_tx_state_t             transmitter FSM states
//   UART_DEFAULT_CLKS_PER_BIT   50 MHz / 115200 baud
//   UART_DATA_BITS              data bits per 8N1 frame
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  localparam int UART_DEFAULT_CLKS_PER_BIT = 434;
  localparam int UART_DATA_BITS            = 8;

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 serial transmitter driven by an active-low start strobe
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   start_n  active-low transmit request; a falling edge seen in IDLE starts a frame
//   tx_byte  byte to send, captured on the accepting edge only
//   ready    1 = idle and able to accept, 0 = frame in progress (registered)
//   tx       serial line, idles high (registered)
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_n,
  input  logic [7:0] tx_byte,
  output logic       ready,
  output logic       tx
);

  localparam int              BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      BIT_LAST  = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t state;
  logic           start_n_q;
  logic [BW-1:0]  baud_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;

  // Falling edge only: a strobe held low never retriggers.
  logic req;
  assign req = !start_n && start_n_q;

  logic bit_done;
  assign bit_done = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tx        <= 1'b1;
      ready     <= 1'b1;
      start_n_q <= 1'b1;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
    end else begin
      start_n_q <= start_n;
      case (state)
        IDLE: begin
          tx    <= 1'b1;
          ready <= 1'b1;
          if (req) begin
            shift    <= tx_byte;
            bit_idx  <= '0;
            baud_cnt <= '0;
            state    <= START;
            tx       <= 1'b0;
            ready    <= 1'b0;
          end
        end
        START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            state    <= DATA;
            tx       <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            shift    <= shift >> 1;
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == BIT_LAST) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              // Next bit is the one about to land in shift[0].
              tx <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        STOP: begin
          // A request arriving on the leaving edge is dropped: state is not IDLE yet.
          if (bit_done) begin
            baud_cnt <= '0;
            state    <= IDLE;
            ready    <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       rst;
  logic       start_n;
  logic [7:0] tx_byte;
  logic       ready;
  logic       tx;

  int n_cmp;
  int n_bad;

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_n (start_n),
    .tx_byte (tx_byte),
    .ready   (ready),
    .tx      (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Request one frame and check tx/ready on every cycle of it.
  // release_at: loop cycle at which start_n returns high (-1 = stay low).
  // glitch: inject a second falling edge at cycle 20 of the frame.
  task automatic run_frame(input logic [7:0] b, input int release_at, input bit glitch);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    @(negedge clk);
    tx_byte = b;
    start_n = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      check_eq($sformatf("tx_%02h_c%0d", b, i), {31'd0, tx}, {31'd0, frame[i / CPB]});
      check_eq($sformatf("rdy_%02h_c%0d", b, i), {31'd0, ready}, 32'd0);
      if (i == 2) tx_byte = ~b;
      if (i == release_at) start_n = 1'b1;
      if (glitch && i == 17) start_n = 1'b1;
      if (glitch && i == 19) start_n = 1'b0;
      if (glitch && i == 23) start_n = 1'b1;
    end
    @(negedge clk);
    check_eq($sformatf("rdy_end_%02h", b), {31'd0, ready}, 32'd1);
    check_eq($sformatf("tx_end_%02h", b), {31'd0, tx}, 32'd1);
  endtask

  task automatic check_idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check_eq($sformatf("%s_rdy_c%0d", tag, i), {31'd0, ready}, 32'd1);
      check_eq($sformatf("%s_tx_c%0d", tag, i), {31'd0, tx}, 32'd1);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    start_n = 1'b1;
    tx_byte = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("reset_tx", {31'd0, tx}, 32'd1);
    check_eq("reset_ready", {31'd0, ready}, 32'd1);
    rst = 1'b0;
    check_idle("post_reset", 5);

    // Basic frame and LSB-first ordering.
    run_frame(8'h55, 1, 1'b0);
    check_idle("gap1", 3);
    run_frame(8'h01, 1, 1'b0);
    check_idle("gap2", 3);
    run_frame(8'h80, 1, 1'b0);
    check_idle("gap3", 3);

    // Held strobe: exactly one frame, ready stays high afterwards.
    run_frame(8'hA3, -1, 1'b0);
    check_idle("held", 60);
    start_n = 1'b1;
    check_idle("held_rel", 2);

    // Second falling edge at cycle 20 of a frame is ignored.
    run_frame(8'hC6, 1, 1'b1);
    check_idle("busy", 45);

    // Memory-map handshake: poll ready, write, release on ready rise.
    check_eq("poll_41", {31'd0, ready}, 32'd1);
    run_frame(8'h41, -1, 1'b0);
    start_n = 1'b1;
    @(negedge clk);
    check_eq("poll_42", {31'd0, ready}, 32'd1);
    run_frame(8'h42, -1, 1'b0);
    start_n = 1'b1;
    check_idle("hs_done", 3);

    // Reset mid-DATA with a zero byte so tx is low before reset.
    @(negedge clk);
    tx_byte = 8'h00;
    start_n = 1'b0;
    repeat (15) @(negedge clk);
    start_n = 1'b1;
    check_eq("pre_rst_tx", {31'd0, tx}, 32'd0);
    check_eq("pre_rst_ready", {31'd0, ready}, 32'd0);
    rst = 1'b1;
    #1;
    check_eq("async_rst_tx", {31'd0, tx}, 32'd1);
    check_eq("async_rst_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    check_idle("after_rst", 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
